data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (port p_*) and the debug/loader port (port d_*). The loader initialises and inspects data memory at run time.
- Sequences each access through a configurable fixed-latency memory cycle.
- Returns read data with a one-cycle done pulse.
- Drives a stall to the pipeline while its access is pending.
- Fixed priority goes to the pipeline, with a starvation guard for the loader.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, memory wait cycles before read data is valid (0..15)
STARVE_MAX, 4, consecutive pipeline grants allowed while the loader is waiting (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
p_req  in  1  pipeline access request, held until p_done
p_we  in  1  pipeline write enable
p_addr  in  ADDR_W  pipeline address
p_wdata  in  DATA_W  pipeline write data
p_rdata  out  DATA_W  pipeline read data
p_done  out  1  one-cycle completion pulse
p_stall  out  1  pipeline stall
d_req  in  1  loader request, held until d_done
d_we  in  1  loader write enable
d_addr  in  ADDR_W  loader address
d_wdata  in  DATA_W  loader write data
d_rdata  out  DATA_W  loader read data
d_done  out  1  one-cycle completion pulse
m_en  out  1  memory enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE.
  - m_en, m_we, m_addr, m_wdata, p_done, d_done, p_rdata, d_rdata, starve counter, latency counter all 0.
  - Any in-flight access is aborted with no done pulse.
- Requester rules: req, we, addr and wdata are held stable from req rise until the done cycle. req drops in the done cycle.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high at the edge, latch the grant and register m_en=1, m_we/m_addr/m_wdata from the winner.
  - Load the latency counter with MEM_LAT and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - m_* held constant; counter decrements each edge.
  - At the edge where the counter==0:
    - Read: capture m_rdata into the winner's x_rdata.
    - Write: x_rdata holds its previous value.
    - Set the winner's x_done=1 and m_en=m_we=0; go to RESP.
- RESP:
  - x_done high for this cycle only; no arbitration.
  - Next edge: clear done and go to IDLE.
- Latency:
  - Req rise in cycle 0 gives done in cycle MEM_LAT+2.
  - m_en is high for cycles 1..MEM_LAT+1.
  - Minimum spacing between accesses is MEM_LAT+3 cycles.
- p_stall = p_req & ~p_done (combinational). It is high from the first p_req cycle through the cycle before p_done.
- Arbitration (IDLE only):
  - Only one req high: that requester wins.
  - Both high: pipeline wins, unless starve counter == STARVE_MAX, in which case the loader wins.
- Starve counter:
  - +1 on each pipeline grant while d_req=1.
  - Cleared on a loader grant, and in any IDLE cycle with d_req=0.
  - Saturates at STARVE_MAX.
- Latency counter width: max(1, clog2(MEM_LAT+1)). MEM_LAT=0 gives a one-cycle ACCESS.
- x_rdata outputs are registered and hold until the next read completion on that port.
- A requester that drops req mid-access is a protocol violation; the access still completes and done still pulses.

Test Plan:
1. Hold rst=0 for 2 cycles with p_req=1 -> all registered outputs 0, state IDLE, p_stall=1. Release rst=1 -> pipeline read completes normally.
2. MEM_LAT=1, memory[0x10]=0xDEADBEEF; p_req rises in cycle 0 with p_addr=0x10 -> m_en=1, m_addr=0x10 in cycles 1-2; p_done=1 and p_rdata=0xDEADBEEF in cycle 3; p_stall=1 in cycles 0-2, 0 in cycle 3.
3. Loader write d_addr=0x20, d_wdata=0x12345678 -> m_we=1 with those values for MEM_LAT+1 cycles; d_done in cycle MEM_LAT+2; d_rdata unchanged; memory[0x20]=0x12345678.
4. STARVE_MAX=4, p_req re-asserted every cycle after p_done, d_req held high -> grants go P,P,P,P,D; the pattern repeats after the loader is served.
5. p_req and d_req rise in the same cycle with starve counter 0 -> pipeline served first; loader served immediately after the pipeline's RESP; d_rdata is correct.
6. rst=0 for one cycle during ACCESS -> no done pulse, m_en=0 next cycle, state IDLE; a re-issued request completes with correct data.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundle of every signal between the data-memory arbiter and its two
// requesters (pipeline MEM stage p_*, debug/loader d_*) plus the single-port
// data memory (m_*).
//
// Modports
//   slave  : the arbiter. It takes p_/d_ requests, returns rdata/done/stall,
//            drives m_* and takes m_rdata.
//   master : the environment around the arbiter, which holds both requesters
//            and the memory. It is the mirror image of slave.
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // pipeline port
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_done;
    logic              p_stall;
    // loader port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    // memory port
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_done, p_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_done, p_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port data memory between the pipeline MEM stage (p_*)
// and the debug/loader port (d_*). Each access runs as IDLE -> ACCESS -> RESP.
// The memory cycle lasts a fixed MEM_LAT+1 cycles. The requester then gets a
// one-cycle done pulse, and for reads the registered read data.
// The pipeline has priority. The loader is forced through after STARVE_MAX
// consecutive pipeline grants while it waits.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : data_mem_arbiter_if.slave
//          p_req/p_we/p_addr/p_wdata -> p_rdata/p_done/p_stall
//          d_req/d_we/d_addr/d_wdata -> d_rdata/d_done
//          m_en/m_we/m_addr/m_wdata  <- m_rdata
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,   // 0..15
    parameter int STARVE_MAX = 4    // >= 1
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);

    localparam int LAT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t           state;
    logic             gnt_d;     // 1: the access in flight belongs to the loader
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve;

    req_t p_r, d_r, win;
    logic any_req, pick_d;

    // Arbitration is combinational here but only consumed in IDLE.
    always_comb begin
        p_r     = '{we: bus.p_we, addr: bus.p_addr, wdata: bus.p_wdata};
        d_r     = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
        any_req = bus.p_req | bus.d_req;
        // The loader wins when it is alone or when the starve counter is full.
        pick_d  = bus.d_req & (~bus.p_req | (starve == STV_TOP));
        win     = pick_d ? d_r : p_r;
    end

    // The stall drops in the done cycle so the pipeline can advance there.
    assign bus.p_stall = bus.p_req & ~bus.p_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            gnt_d       <= 1'b0;
            lat_cnt     <= '0;
            starve      <= '0;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.p_done  <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.p_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_d       <= pick_d;
                        bus.m_en    <= 1'b1;
                        bus.m_we    <= win.we;
                        bus.m_addr  <= win.addr;
                        bus.m_wdata <= win.wdata;
                        lat_cnt     <= LAT_LOAD;
                        state       <= ACCESS;
                    end
                    // Count only pipeline grants that make a waiting loader
                    // wait longer. Any loader grant, or any IDLE cycle with
                    // no loader waiting, clears the count.
                    if (pick_d || !bus.d_req)
                        starve <= '0;
                    else if (bus.p_req && starve != STV_TOP)
                        starve <= starve + 1'b1;
                end

                ACCESS: begin
                    if (lat_cnt == '0) begin
                        if (!bus.m_we) begin
                            if (gnt_d) bus.d_rdata <= bus.m_rdata;
                            else       bus.p_rdata <= bus.m_rdata;
                        end
                        if (gnt_d) bus.d_done <= 1'b1;
                        else       bus.p_done <= 1'b1;
                        bus.m_en <= 1'b0;
                        bus.m_we <= 1'b0;
                        state    <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                RESP: begin
                    bus.p_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Internal consistency properties.
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(bus.p_done && bus.d_done));
    a_en_in_access: assert property (@(posedge clk) disable iff (!rst)
        (state == ACCESS) == bus.m_en);
    a_starve_bound: assert property (@(posedge clk) disable iff (!rst)
        starve <= STV_TOP);

endmodule
